// File: rtl/fifo_burst_packer.sv
// Drains bytes from the async video FIFO read side, packs them into 32-bit words and
// streams arbiter-granted bursts. FIFO_BURST_PACKER_BYTE_SWAP_EN selects big-endian packing.
//
// state | meaning
// IDLE  | watching water level / flush_pending for the next burst
// REQ   | burst_req held until the arbiter acknowledges
// XFER  | reading, packing and streaming words until the last one is accepted
module fifo_burst_packer #(
  parameter int BURST_LEN   = 16,
  parameter int LEVEL_WIDTH = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   fifo_rd_en,
  input  logic [7:0]             fifo_rd_data,
  input  logic                   fifo_rd_empty,
  input  logic [LEVEL_WIDTH-1:0] fifo_rd_water_level,
  input  logic                   flush,
  output logic                   burst_req,
  input  logic                   burst_ack,
  output logic [6:0]             burst_len,
  output logic [31:0]            m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_last,
  output logic                   busy
);
  localparam int FULL_BYTES = BURST_LEN * 4;

  typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;
  state_t state, state_next;

  logic        flush_pending, is_flush;
  logic [8:0]  bytes_rem;
  logic [6:0]  words_pushed;
  logic        inflight;
  logic [31:0] pack_word, pack_next;
  logic [2:0]  pack_cnt, cnt_next;
  logic [31:0] buf_data [2];
  logic [1:0]  buf_last;
  logic        wr_ptr, rd_ptr;
  logic [1:0]  buf_cnt;

  logic        start_full, start_flush, pop, push, pack_rdy, last_pop;
  logic [4:0]  outstanding;
  logic [6:0]  flush_words;
  logic [1:0]  lane;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    start_full  = fifo_rd_water_level >= LEVEL_WIDTH'(FULL_BYTES);
    start_flush = !start_full && flush_pending && (fifo_rd_water_level != '0);
    flush_words = {1'b0, fifo_rd_water_level[7:2]} + {6'd0, |fifo_rd_water_level[1:0]};

    burst_req = (state == REQ);
    busy      = (state != IDLE);
    m_valid   = (state == XFER) && (buf_cnt != 2'd0);
    m_data    = m_valid ? buf_data[rd_ptr] : 32'd0;
    m_last    = m_valid && buf_last[rd_ptr];
    pop       = m_valid && m_ready;
    last_pop  = pop && m_last;

    // A partial word only completes once every byte of the burst has landed.
    pack_rdy    = (pack_cnt == 3'd4) || ((pack_cnt != 3'd0) && (bytes_rem == 9'd0) && !inflight);
    push        = (state == XFER) && pack_rdy && ((buf_cnt != 2'd2) || pop);
    outstanding = {4'd0, inflight} + {2'd0, pack_cnt} + {1'b0, buf_cnt, 2'b00};
    fifo_rd_en  = (state == XFER) && (bytes_rem != 9'd0) && !fifo_rd_empty && (outstanding < 5'd12);

    pack_next = push ? 32'd0 : pack_word;
    cnt_next  = push ? 3'd0 : pack_cnt;
`ifdef FIFO_BURST_PACKER_BYTE_SWAP_EN
    lane = 2'd3 - cnt_next[1:0];
`else
    lane = cnt_next[1:0];
`endif
    if (inflight) begin
      pack_next[{lane, 3'b000} +: 8] = fifo_rd_data;
      cnt_next = cnt_next + 3'd1;
    end

    case (state)
      IDLE: if (start_full || start_flush) state_next = REQ;
      REQ:  if (burst_ack) state_next = XFER;
      XFER: if (last_pop) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flush_pending <= 1'b0;
      is_flush      <= 1'b0;
      bytes_rem     <= '0;
      burst_len     <= '0;
      words_pushed  <= '0;
      inflight      <= 1'b0;
      pack_word     <= '0;
      pack_cnt      <= '0;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      buf_cnt       <= '0;
      buf_last      <= '0;
      buf_data[0]   <= '0;
      buf_data[1]   <= '0;
    end else begin
      if (flush)
        flush_pending <= 1'b1;
      else if (state == XFER && last_pop && is_flush)
        flush_pending <= 1'b0;
      else if (state == IDLE && fifo_rd_water_level == '0 && pack_cnt == 3'd0)
        flush_pending <= 1'b0;

      inflight  <= fifo_rd_en;
      pack_word <= pack_next;
      pack_cnt  <= cnt_next;
      if (fifo_rd_en) bytes_rem <= bytes_rem - 9'd1;

      if (push) begin
        buf_data[wr_ptr] <= pack_word;
        buf_last[wr_ptr] <= (words_pushed == burst_len - 7'd1);
        wr_ptr           <= ~wr_ptr;
        words_pushed     <= words_pushed + 7'd1;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      buf_cnt <= buf_cnt + {1'b0, push} - {1'b0, pop};

      // Level is sampled only here, on the way out of IDLE.
      if (state == IDLE && (start_full || start_flush)) begin
        burst_len    <= start_full ? 7'(BURST_LEN) : flush_words;
        bytes_rem    <= start_full ? 9'(FULL_BYTES) : {1'b0, fifo_rd_water_level[7:0]};
        is_flush     <= !start_full;
        words_pushed <= '0;
      end
    end
  end
endmodule

// File: tb/tb_fifo_burst_packer.sv
// Randomized scoreboard bench for fifo_burst_packer: a FIFO model feeds bytes, a burst
// planner predicts words, and a monitor checks every accepted word and burst length.
module tb_fifo_burst_packer;
  localparam int BURST_LEN   = 16;
  localparam int LEVEL_WIDTH = 12;
  localparam int FULL_BYTES  = BURST_LEN * 4;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   fifo_rd_en;
  logic [7:0]             fifo_rd_data = 8'h00;
  logic                   fifo_rd_empty = 1'b1;
  logic [LEVEL_WIDTH-1:0] fifo_rd_water_level = '0;
  logic                   flush = 1'b0;
  logic                   burst_req;
  logic                   burst_ack = 1'b0;
  logic [6:0]             burst_len;
  logic [31:0]            m_data;
  logic                   m_valid;
  logic                   m_ready = 1'b1;
  logic                   m_last;
  logic                   busy;

  fifo_burst_packer #(.BURST_LEN(BURST_LEN), .LEVEL_WIDTH(LEVEL_WIDTH)) dut (
    .clk(clk), .rst(rst),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_rd_empty(fifo_rd_empty),
    .fifo_rd_water_level(fifo_rd_water_level), .flush(flush),
    .burst_req(burst_req), .burst_ack(burst_ack), .burst_len(burst_len),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [7:0]  src_q[$];
  logic [7:0]  bq[$];
  logic [32:0] exp_q[$];
  int          blen_q[$];
  logic [32:0] e_word;
  int  ready_mode = 0, ready_phase = 0, ack_delay = 0, req_cycles = 0;
  bit  rd_taken = 0, req_seen = 0, prev_stall = 0;
  logic [31:0] prev_data = '0;
  logic        prev_last = 1'b0;
  int  rd_total = 0, req_count = 0, burst_reads = 0, burst_acc = 0, max_out = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] place(input logic [7:0] b, input int j);
`ifdef FIFO_BURST_PACKER_BYTE_SWAP_EN
    return {24'h0, b} << (8 * (3 - j));
`else
    return {24'h0, b} << (8 * j);
`endif
  endfunction

  // Reference: a burst is ceil(n/4) words, bytes fill lanes in order, missing bytes are zero.
  task automatic add_burst(input int pos, input int cnt);
    int words;
    logic [31:0] w;
    words = (cnt + 3) / 4;
    blen_q.push_back(words);
    for (int k = 0; k < words; k++) begin
      w = '0;
      for (int j = 0; j < 4; j++)
        if (k * 4 + j < cnt) w = w | place(bq[pos + k * 4 + j], j);
      exp_q.push_back({(k == words - 1), w});
    end
  endtask

  task automatic plan(input bit with_flush);
    int pos;
    pos = 0;
    while (bq.size() - pos >= FULL_BYTES) begin
      add_burst(pos, FULL_BYTES);
      pos += FULL_BYTES;
    end
    if (with_flush && bq.size() > pos) add_burst(pos, bq.size() - pos);
  endtask

  task automatic fill_rand(input int n);
    bq.delete();
    repeat (n) bq.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic send(input bit with_flush);
    foreach (bq[i]) src_q.push_back(bq[i]);
    plan(with_flush);
  endtask

  task automatic pulse_flush();
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic wait_done(input string name);
    int cyc;
    cyc = 0;
    do begin
      @(negedge clk); #2;
      cyc++;
    end while (!(exp_q.size() == 0 && blen_q.size() == 0 && !busy) && cyc < 4000);
    check({name, "_done"}, (exp_q.size() == 0 && blen_q.size() == 0 && !busy), 1);
  endtask

  // FIFO read side, arbiter and downstream ready, all driven at the falling edge.
  always @(negedge clk) begin
    if (rd_taken) begin
      if (src_q.size() != 0) fifo_rd_data = src_q.pop_front();
      else fifo_rd_data = 8'h00;
    end
    fifo_rd_water_level = LEVEL_WIDTH'(src_q.size());
    fifo_rd_empty = (src_q.size() == 0);
    if (req_seen) req_cycles++;
    else req_cycles = 0;
    burst_ack = req_seen && (req_cycles > ack_delay);
    case (ready_mode)
      0: m_ready = 1'b1;
      1: m_ready = 1'($urandom_range(0, 1));
      default: m_ready = (ready_phase % 4 == 0) || (ready_phase % 4 == 3);
    endcase
    ready_phase++;
  end

  always @(negedge clk) begin
    #1;
    if (!rst) begin
      if (prev_stall) begin
        check("stall_valid", m_valid, 1);
        check("stall_data", m_data, prev_data);
        check("stall_last", m_last, prev_last);
      end
      if (burst_req && !req_seen) begin
        req_count++;
        burst_reads = 0; burst_acc = 0; max_out = 0;
        check("burst_planned", (blen_q.size() != 0), 1);
        if (blen_q.size() != 0) check("burst_len", burst_len, blen_q.pop_front());
      end
      if (fifo_rd_en) begin
        rd_total++;
        burst_reads++;
      end
      if (m_valid && m_ready) begin
        check("word_planned", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e_word = exp_q.pop_front();
          check("m_data", m_data, e_word[31:0]);
          check("m_last", m_last, e_word[32]);
        end
        burst_acc++;
      end
      if (burst_reads - 4 * burst_acc > max_out) max_out = burst_reads - 4 * burst_acc;
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end else begin
      prev_stall = 1'b0;
    end
    req_seen = burst_req;
    rd_taken = fifo_rd_en;
  end

  task automatic check_all_zero(input string name);
    check({name, "_rd_en"}, fifo_rd_en, 0);
    check({name, "_req"}, burst_req, 0);
    check({name, "_len"}, burst_len, 0);
    check({name, "_valid"}, m_valid, 0);
    check({name, "_last"}, m_last, 0);
    check({name, "_data"}, m_data, 0);
    check({name, "_busy"}, busy, 0);
  endtask

  initial begin
    int rd0, req0, cyc, kind, k, d;

    idle_cycles(3);
    check_all_zero("reset");
    @(negedge clk); rst = 1'b0;
    idle_cycles(2);

    // Full burst of an incrementing pattern.
    ack_delay = 2; ready_mode = 0;
    rd0 = rd_total;
    bq.delete();
    for (int i = 0; i < FULL_BYTES; i++) bq.push_back(8'(i));
    @(negedge clk); send(1'b0);
    wait_done("full_inc");
    check("full_inc_reads", rd_total - rd0, FULL_BYTES);

    // One byte short of a burst and no flush: nothing must happen.
    rd0 = rd_total; req0 = req_count;
    fill_rand(FULL_BYTES - 1);
    @(negedge clk); send(1'b0);
    idle_cycles(60);
    check("short_no_req", req_count - req0, 0);
    check("short_no_reads", rd_total - rd0, 0);
    check("short_busy", busy, 0);
    @(negedge clk); src_q.delete();
    idle_cycles(2);

    // Six bytes flushed as a short padded burst.
    bq.delete();
    for (int i = 0; i < 6; i++) bq.push_back(8'hA0 + 8'(i));
    @(negedge clk); send(1'b1);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    wait_done("flush6");
    check("flush6_busy", busy, 0);
    req0 = req_count;
    fill_rand(5);
    @(negedge clk); send(1'b0);
    idle_cycles(40);
    check("flush6_pending_cleared", req_count - req0, 0);
    @(negedge clk); src_q.delete();
    idle_cycles(2);

    // Flush with nothing buffered: pending must clear before new bytes arrive.
    req0 = req_count;
    pulse_flush();
    @(negedge clk);
    fill_rand(10);
    send(1'b0);
    idle_cycles(40);
    check("empty_flush_no_req", req_count - req0, 0);
    @(negedge clk); src_q.delete();
    idle_cycles(2);

    // Backpressure pattern 1-0-0-1.
    ready_mode = 2; ready_phase = 0; ack_delay = 1;
    rd0 = rd_total;
    fill_rand(FULL_BYTES);
    @(negedge clk); send(1'b0);
    wait_done("stall");
    check("stall_outstanding_le12", (max_out <= 12), 1);
    check("stall_reads", rd_total - rd0, FULL_BYTES);

    // Reset in the middle of a transfer.
    ready_mode = 0; ack_delay = 0; burst_acc = 0;
    fill_rand(FULL_BYTES);
    @(negedge clk); send(1'b0);
    cyc = 0;
    while (burst_acc < 5 && cyc < 2000) begin
      @(negedge clk); #2;
      cyc++;
    end
    check("midrst_reached_5_words", (burst_acc >= 5), 1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #2;
    check_all_zero("midrst");
    exp_q.delete(); blen_q.delete();
    @(negedge clk); src_q.delete();
    idle_cycles(4);
    check("midrst_idle", busy, 0);
    rd0 = rd_total;
    fill_rand(FULL_BYTES);
    @(negedge clk); send(1'b0);
    wait_done("after_rst");
    check("after_rst_reads", rd_total - rd0, FULL_BYTES);

    // Randomized mix of full, flush-only and full-plus-flush traffic.
    for (int it = 0; it < 14; it++) begin
      kind = $urandom_range(0, 2);
      ready_mode = $urandom_range(0, 2);
      ack_delay = $urandom_range(0, 3);
      k = $urandom_range(1, FULL_BYTES - 1);
      case (kind)
        0: fill_rand(FULL_BYTES);
        1: fill_rand(k);
        default: fill_rand(FULL_BYTES + k);
      endcase
      @(negedge clk); send(kind != 0);
      if (kind != 0) begin
        d = $urandom_range(0, 20);
        repeat (d) @(negedge clk);
        pulse_flush();
      end
      wait_done("rand");
      check("rand_outstanding_le12", (max_out <= 12), 1);
      check("rand_fifo_drained", src_q.size(), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
